// File: rtl/cache_l2_fa_responder.sv
// L2 responder: 8-line fully associative, 2-word lines, write-through / no-write-allocate.
// Define CACHE_L2_LRU_EN for age-based LRU replacement; the default build uses a round-robin pointer.
module cache_l2_fa_responder #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 17,
  parameter int LINES  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              l1_req,
  input  logic              l1_wren,
  input  logic [ADDR_W-1:0] l1_addr,
  input  logic [DATA_W-1:0] l1_wdata,
  output logic              l1_ack,
  output logic [DATA_W-1:0] l1_rdata,
  output logic              l1_hit,
  output logic              mem_req,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int TAG_W = ADDR_W - 1;
  localparam int IDX_W = $clog2(LINES);

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_WR, FILL0, FILL1, RESP} state_t;

  state_t            state;
  logic              req_wren;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              hit_q;
  logic [IDX_W-1:0]  line_q;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags  [LINES];
  logic [DATA_W-1:0] word0 [LINES];
  logic [DATA_W-1:0] word1 [LINES];

  logic [TAG_W-1:0]  req_tag;
  logic              hit, any_free, fill_done;
  logic [IDX_W-1:0]  hit_idx, free_idx, victim_idx;

  assign req_tag   = req_addr[ADDR_W-1:1];
  assign fill_done = (state == FILL1) && mem_req && mem_ack;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    any_free = 1'b0;
    free_idx = '0;
    // Descending scan: the lowest matching / lowest invalid index wins.
    for (int i = LINES - 1; i >= 0; i--) begin
      if (valid[i] && tags[i] == req_tag) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (!valid[i]) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

`ifdef CACHE_L2_LRU_EN
  logic [IDX_W-1:0] age [LINES];
  logic [IDX_W-1:0] lru_idx, touch_idx;
  logic             touch;

  assign touch     = fill_done || (state == LOOKUP && hit);
  assign touch_idx = fill_done ? line_q : hit_idx;

  always_comb begin
    lru_idx = '0;
    for (int i = 0; i < LINES; i++)
      if (age[i] == IDX_W'(LINES - 1)) lru_idx = IDX_W'(i);
  end

  assign victim_idx = any_free ? free_idx : lru_idx;

  // Ages start as a permutation (age[i] = i) so exactly one line always holds the oldest age.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LINES; i++) age[i] <= IDX_W'(i);
    end else if (touch) begin
      for (int i = 0; i < LINES; i++) begin
        if (IDX_W'(i) == touch_idx)        age[i] <= '0;
        else if (age[i] < age[touch_idx])  age[i] <= age[i] + 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr;
  logic             evict_q;

  assign victim_idx = any_free ? free_idx : rr_ptr;

  // The pointer only moves when a fill actually displaced a valid line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr  <= '0;
      evict_q <= 1'b0;
    end else begin
      if (state == LOOKUP && !req_wren && !hit) evict_q <= !any_free;
      if (fill_done && evict_q)                 rr_ptr  <= rr_ptr + 1'b1;
    end
  end
`endif

  // NOTE: line storage has no reset; the valid bits alone qualify its contents.
  always_ff @(posedge clk) begin
    if (state == LOOKUP && req_wren && hit) begin
      if (req_addr[0]) word1[hit_idx] <= req_wdata;
      else             word0[hit_idx] <= req_wdata;
    end
    if (state == FILL0 && mem_ack) word0[line_q] <= mem_rdata;
    if (fill_done) begin
      word1[line_q] <= mem_rdata;
      tags[line_q]  <= req_tag;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      req_wren  <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      hit_q     <= 1'b0;
      line_q    <= '0;
      valid     <= '0;
      l1_ack    <= 1'b0;
      l1_rdata  <= '0;
      l1_hit    <= 1'b0;
      mem_req   <= 1'b0;
      mem_wren  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: if (l1_req) begin
          req_wren  <= l1_wren;
          req_addr  <= l1_addr;
          req_wdata <= l1_wdata;
          state     <= LOOKUP;
        end
        LOOKUP: begin
          hit_q  <= hit;
          line_q <= hit ? hit_idx : victim_idx;
          if (req_wren) begin
            mem_req   <= 1'b1;
            mem_wren  <= 1'b1;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
            state     <= MEM_WR;
          end else if (hit) begin
            l1_ack   <= 1'b1;
            l1_hit   <= 1'b1;
            l1_rdata <= req_addr[0] ? word1[hit_idx] : word0[hit_idx];
            state    <= RESP;
          end else begin
            // The victim stays invalid until both words of the new line have arrived.
            valid[victim_idx] <= 1'b0;
            mem_req           <= 1'b1;
            mem_wren          <= 1'b0;
            mem_addr          <= {req_tag, 1'b0};
            state             <= FILL0;
          end
        end
        MEM_WR: if (mem_ack) begin
          mem_req  <= 1'b0;
          mem_wren <= 1'b0;
          l1_ack   <= 1'b1;
          l1_hit   <= hit_q;
          l1_rdata <= req_wdata;
          state    <= RESP;
        end
        FILL0: if (mem_ack) begin
          mem_req <= 1'b0;
          state   <= FILL1;
        end
        FILL1: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= {req_tag, 1'b1};
          end else if (mem_ack) begin
            mem_req        <= 1'b0;
            valid[line_q]  <= 1'b1;
            l1_ack         <= 1'b1;
            l1_hit         <= 1'b0;
            l1_rdata       <= req_addr[0] ? mem_rdata : word0[line_q];
            state          <= RESP;
          end
        end
        RESP: begin
          l1_ack <= 1'b0;
          l1_hit <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
